// File: rtl/flop_seq.sv
// Purpose: sequences active-low clear/set strobes into an external flop bank, with optional readback compare.
// Latency: 3 cycles acceptance-to-ack with readback, 2 without; INIT holds the bank cleared INIT_CYCLES cycles after reset.
// Backpressure: req is only accepted in IDLE (busy=0); a held req restarts on the first IDLE cycle after DONE.
// Build option: define FLOP_SEQ_READBACK_EN to include the CHECK state, match compare and sticky err.
module flop_seq #(
   parameter int WIDTH       = 8,
   parameter int INIT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [WIDTH-1:0] val,
   input  logic [WIDTH-1:0] mask,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] clr_n,
   output logic [WIDTH-1:0] set_n,
   output logic             busy,
   output logic             ack,
   output logic             match,
   output logic             err
);

   localparam logic [2:0] S_INIT  = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_DRIVE = 3'd2;
`ifdef FLOP_SEQ_READBACK_EN
   localparam logic [2:0] S_CHECK = 3'd3;
`endif
   localparam logic [2:0] S_DONE  = 3'd4;

   // Terminal INIT count: the transition to IDLE happens on the INIT_CYCLES-th edge after release.
   localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

   // INIT_CYCLES outside 1..255 cannot be represented by the 8-bit counter.
   if (INIT_CYCLES < 1 || INIT_CYCLES > 255) begin : g_bad_init
      $error("flop_seq: INIT_CYCLES must be in 1..255");
   end

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [7:0] cnt;

   // Next-state decode; DRIVE, CHECK and DONE are single-cycle states.
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (cnt == INIT_LAST) state_nxt = S_IDLE;
         S_IDLE:  if (req) state_nxt = S_DRIVE;
`ifdef FLOP_SEQ_READBACK_EN
         S_DRIVE: state_nxt = S_CHECK;
         S_CHECK: state_nxt = S_DONE;
`else
         S_DRIVE: state_nxt = S_DONE;
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_INIT;
      endcase
   end

   // State register; reset parks the machine in INIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // INIT cycle counter; starts counting on the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (state == S_INIT && state_nxt == S_INIT) begin
         cnt <= cnt + 8'd1;
      end
   end

   // Registered strobes and status, decoded from the state being entered so they line up with it.
   // DRIVE is only entered from IDLE on acceptance, so val/mask here are the accepted values;
   // mask&val and mask&~val are disjoint, so a bit never sees clr_n and set_n low together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_n <= '0;
         set_n <= '1;
         busy  <= 1'b1;
         ack   <= 1'b0;
      end else begin
         clr_n <= '1;
         set_n <= '1;
         busy  <= 1'b1;
         ack   <= 1'b0;
         case (state_nxt)
            S_INIT:  clr_n <= '0;
            S_IDLE:  busy  <= 1'b0;
            S_DRIVE: begin
               set_n <= ~(mask & val);
               clr_n <= ~(mask & ~val);
            end
            S_DONE:  ack   <= 1'b1;
            default: ;
         endcase
      end
   end

`ifdef FLOP_SEQ_READBACK_EN
   logic [WIDTH-1:0] val_l;
   logic [WIDTH-1:0] mask_l;
   logic             cmp_ok;

   // Capture the accepted pattern so later input changes cannot disturb the readback compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_l  <= '0;
         mask_l <= '0;
      end else if (state == S_IDLE && req) begin
         val_l  <= val;
         mask_l <= mask;
      end
   end

   // Only masked bits take part; an all-zero mask always compares equal.
   assign cmp_ok = ((q & mask_l) == (val_l & mask_l));

   // Readback result lands at the end of CHECK, so it is visible together with ack in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match <= 1'b0;
         err   <= 1'b0;
      end else if (state == S_CHECK) begin
         match <= cmp_ok;
         if (!cmp_ok) begin
            err <= 1'b1;
         end
      end
   end
`else
   logic unused_q;

   // Without readback the bank is never sampled.
   assign unused_q = ^q;

   // No compare is possible, so every completed operation reports a match and err never sets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match <= 1'b0;
         err   <= 1'b0;
      end else if (state == S_DRIVE) begin
         match <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_flop_seq.sv
// Bench for flop_seq: an ideal flop bank (with stuck-at-0 injection) closes the readback loop.
// A cycle-level reference model predicts all outputs each cycle and pushes expected completions;
// a separate monitor pops them whenever the DUT pulses ack.
`timescale 1ns/1ps
module tb_flop_seq;
   localparam int WIDTH       = 8;
   localparam int INIT_CYCLES = 4;
`ifdef FLOP_SEQ_READBACK_EN
   localparam int LAT = 3;
   localparam bit RB  = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit RB  = 1'b0;
`endif

   logic             clk  = 1'b0;
   logic             rst  = 1'b1;
   logic             req  = 1'b0;
   logic [WIDTH-1:0] val  = '0;
   logic [WIDTH-1:0] mask = '0;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] clr_n;
   logic [WIDTH-1:0] set_n;
   logic             busy;
   logic             ack;
   logic             match;
   logic             err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   flop_seq #(.WIDTH(WIDTH), .INIT_CYCLES(INIT_CYCLES)) dut (
      .clk(clk), .rst(rst), .req(req), .val(val), .mask(mask), .q(q),
      .clr_n(clr_n), .set_n(set_n), .busy(busy), .ack(ack), .match(match), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Ideal bank of flops with synchronous active-low clear/set; stuck bits read back as 0.
   logic [WIDTH-1:0] bank  = '0;
   logic [WIDTH-1:0] stuck = '0;
   always @(posedge clk) bank <= (bank | ~set_n) & clr_n;
   assign q = bank & ~stuck;

   // Scoreboard of expected completions.
   typedef struct {
      logic m;
      int   acc;
   } exp_t;
   exp_t sb[$];

   // Reference model state: countdowns rather than an encoded FSM.
   int               init_left = INIT_CYCLES;
   int               op_pos    = 0;        // 0 idle, 1 drive ... LAT done
   logic [WIDTH-1:0] ref_bank  = '0;
   logic [WIDTH-1:0] op_v      = '0;
   logic [WIDTH-1:0] op_m      = '0;
   logic             pend_match = 1'b0;
   logic             exp_match  = 1'b0;
   logic             exp_err    = 1'b0;

   // Per-cycle prediction and comparison, then advance the model across the coming edge.
   always @(negedge clk) begin
      logic [WIDTH-1:0] e_clr;
      logic [WIDTH-1:0] e_set;
      logic             e_busy;
      logic             e_ack;
      e_clr = '1; e_set = '1; e_busy = 1'b1; e_ack = 1'b0;
      if (rst) begin
         e_clr = '0; exp_match = 1'b0; exp_err = 1'b0;
         init_left = INIT_CYCLES; op_pos = 0; ref_bank = '0;
         sb.delete();
      end else if (init_left > 0) begin
         e_clr = '0;
         ref_bank = '0;
      end else if (op_pos == 0) begin
         e_busy = 1'b0;
      end else if (op_pos == 1) begin
         e_set = ~(op_m & op_v);
         e_clr = ~(op_m & ~op_v);
      end else if (op_pos == LAT) begin
         e_ack = 1'b1;
         exp_match = pend_match;
         if (!pend_match) exp_err = 1'b1;
      end
      total++;
      if ({clr_n, set_n, busy, ack, match, err} !== {e_clr, e_set, e_busy, e_ack, exp_match, exp_err}) begin
         bad++;
         $display("FAIL outputs cyc=%0d got clr_n=%h set_n=%h busy=%b ack=%b match=%b err=%b want clr_n=%h set_n=%h busy=%b ack=%b match=%b err=%b",
                  cyc, clr_n, set_n, busy, ack, match, err, e_clr, e_set, e_busy, e_ack, exp_match, exp_err);
      end
      total++;
      if ((~clr_n & ~set_n) !== '0) begin
         bad++;
         $display("FAIL no_conflict cyc=%0d got clr_n=%h set_n=%h want no bit low in both", cyc, clr_n, set_n);
      end
      if (!rst) begin
         if (init_left > 0) begin
            init_left--;
         end else if (op_pos == 0) begin
            if (req) begin
               op_v = val; op_m = mask; op_pos = 1;
               ref_bank = (ref_bank & ~mask) | (val & mask);
               pend_match = RB ? (((ref_bank & ~stuck) & mask) == (val & mask)) : 1'b1;
               sb.push_back('{pend_match, cyc});
            end
         end else if (op_pos == LAT) begin
            op_pos = 0;
         end else begin
            op_pos++;
         end
      end
   end

   // Completion monitor: every ack must match the oldest outstanding request.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && ack === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL ack_unexpected cyc=%0d got ack=1 want no outstanding request", cyc);
         end else begin
            e = sb.pop_front();
            if (match !== e.m || (cyc - e.acc) != LAT) begin
               bad++;
               $display("FAIL ack_check cyc=%0d got match=%b latency=%0d want match=%b latency=%0d",
                        cyc, match, cyc - e.acc, e.m, LAT);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL wait_idle got busy=%b want 0 within 50 cycles", busy);
      end
   endtask

   task automatic do_req(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] m);
      req = 1'b1; val = v; mask = m;
      step();
      req = 1'b0; val = WIDTH'($urandom); mask = WIDTH'($urandom);
      repeat (LAT + 1) step();
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   initial begin
      int n;
      int rises;
      int acks;
      logic prev_busy;

      // Reset pulse and INIT length.
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("init_len", n, INIT_CYCLES);
      check("idle_clr_n", clr_n, 8'hFF);

      // Ideal bank, full mask.
      stuck = '0;
      do_req(8'hA5, 8'hFF);
      check("a5_match", match, 1);

      // Stuck bit 2 inside the mask, then a passing request must leave err set.
      stuck = 8'h04;
      do_req(8'h0F, 8'h0C);
      check("stuck_match", match, RB ? 0 : 1);
      check("stuck_err", err, RB);
      stuck = '0;
      do_req(8'hF0, 8'hFF);
      check("err_sticky", err, RB);

      // Empty mask.
      do_req(8'h5A, 8'h00);
      check("mask0_match", match, 1);

      // req held for 10 cycles with inputs changing every cycle.
      rises = 0; acks = 0; prev_busy = busy;
      req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         val = WIDTH'($urandom); mask = WIDTH'($urandom);
         step();
         if (!prev_busy && busy) rises++;
         if (ack === 1'b1) acks++;
         prev_busy = busy;
      end
      req = 1'b0;
      check("held_accepts", rises, (10 - 1) / (LAT + 1) + 1);
      check("held_acks", acks, (10 - 1 - LAT) / (LAT + 1) + 1);
      wait_idle();

      // Reset in the middle of an operation.
      req = 1'b1; val = 8'h3C; mask = 8'hFF;
      step();
      req = 1'b0;
      repeat (LAT - 2) step();
      rst = 1'b1;
      #1;
      check("midrst_outs", {clr_n, set_n, busy, ack, match, err}, {8'h00, 8'hFF, 4'b1000});
      step();
      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("midrst_init_len", n, INIT_CYCLES);

      // Randomized traffic with occasional resets.
      stuck = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
      for (int i = 0; i < 400; i++) begin
         req  = ($urandom_range(0, 2) != 0);
         val  = WIDTH'($urandom);
         mask = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
         rst  = ($urandom_range(0, 96) == 0);
         step();
      end
      rst = 1'b0; req = 1'b0;
      repeat (INIT_CYCLES + 1) step();
      wait_idle();
      repeat (2) step();
      check("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
